// File: rtl/k_dsp_issue_if.sv
// Handshake and ALU bus between the instruction source, the issue stage and the ALU.
// The master side sends instructions and returns ALU results. The slave side is the issue stage.
interface k_dsp_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [2:0]  alu_selector;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic        alu_result_valid;

  modport master (
    output instr_valid, instr, alu_result, alu_result_valid,
    input  instr_ready, alu_opA, alu_opB, alu_selector, alu_valid
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_result_valid,
    output instr_ready, alu_opA, alu_opB, alu_selector, alu_valid
  );
endinterface

// File: rtl/k_dsp_issue.sv
// k_dsp_issue: operand issue stage in front of the K_DSP ALU.
// Instructions are buffered in a small FIFO and executed strictly one at a time.
// Each instruction reads an 8x32 register file, is issued to the ALU, and the
// returned result is written back to its destination register.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for a FIFO entry; pops it into the instruction register
//   S_ISSUE | one cycle: LOADI writes directly, otherwise strobe alu_valid
//   S_WAIT  | operands held; waiting for alu_result_valid or the timeout
//   S_WB    | one cycle: write the latched result to R[rd]
module k_dsp_issue #(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  k_dsp_issue_if.slave     bus,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired_count,
  input  logic [2:0]       dbg_addr,
  output logic [31:0]      dbg_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(WAIT_LIMIT + 1);
  localparam logic [2:0] OP_LOADI = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t           state_q, state_d;
  logic [15:0]      fifo_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             rdy_en_q;
  logic [15:0]      ir_q, ir_d;
  logic [31:0]      rf_q [8];
  logic [31:0]      res_q, res_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic        empty, full, push, pop;
  logic        rf_we, issue_stb, drive_ops;
  logic [31:0] rf_wdata;
  logic [2:0]  op, rd, rs1, rs2;
  logic [9:0]  imm;

  assign op  = ir_q[15:13];
  assign rd  = ir_q[12:10];
  assign rs1 = ir_q[9:7];
  assign rs2 = ir_q[6:4];
  assign imm = ir_q[9:0];

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // rdy_en_q holds instr_ready low during reset and lets it rise on the first clock afterwards.
  assign bus.instr_ready = rdy_en_q && !full;
  assign push = bus.instr_valid && bus.instr_ready;

  // FIFO pointers and the ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage. It needs no reset because the pointers mark which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= bus.instr;
  end

  // FSM state register and the per-instruction datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      res_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state logic, FIFO pop, register-file write and the issue strobe.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    res_d     = res_q;
    tmr_d     = tmr_q;
    err_d     = err_q;
    ret_d     = ret_q;
    pop       = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = res_q;
    issue_stb = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          ir_d    = fifo_q[rd_ptr_q[AW-1:0]];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op == OP_LOADI) begin
          rf_we    = 1'b1;
          rf_wdata = {22'd0, imm};
          ret_d    = ret_q + 1'b1;
          state_d  = S_IDLE;
        end else begin
          issue_stb = 1'b1;
          tmr_d     = TW'(WAIT_LIMIT - 1);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.alu_result_valid) begin
          res_d   = bus.alu_result;
          state_d = S_WB;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = res_q;
        ret_d    = ret_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file. R0 is never written, so it always reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (rf_we && (rd != 3'd0)) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  // Execution is serial, so nothing writes the register file during WAIT.
  // Reading the operands straight from the register file therefore keeps them stable for the ALU.
  assign drive_ops        = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (op != OP_LOADI);
  assign bus.alu_opA      = drive_ops ? rf_q[rs1] : '0;
  assign bus.alu_opB      = drive_ops ? rf_q[rs2] : '0;
  assign bus.alu_selector = drive_ops ? op : 3'd0;
  assign bus.alu_valid    = issue_stb;

  assign busy          = (state_q != S_IDLE) || !empty;
  assign err           = err_q;
  assign retired_count = ret_q;
  assign dbg_data      = rf_q[dbg_addr];

endmodule

// File: tb/tb_k_dsp_issue.sv
// Directed testbench for k_dsp_issue.
// A behavioural ALU answers a configurable number of cycles after each issue, or never.
module tb_k_dsp_issue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy, err;
  logic [15:0] retired_count;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  k_dsp_issue_if bus();

  k_dsp_issue #(.FIFO_DEPTH(4), .WAIT_LIMIT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err),
    .retired_count(retired_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ALU model controls. 0 means never answer. These are written only by the main sequence.
  int          alu_delay = 1;
  int          spur_req  = 0;
  logic [31:0] spur_data = '0;
  // ALU model observations. These are written only by the model process.
  int          spur_ack  = 0;
  int          n_issue   = 0;
  int          wait_cnt  = 0;
  logic [31:0] pend_res  = '0;
  logic [31:0] cap_a     = '0;
  logic [31:0] cap_b     = '0;
  logic [2:0]  cap_sel   = '0;
  logic [23:0] sel_log   = '0;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  initial begin
    bus.alu_result_valid = 1'b0;
    bus.alu_result       = '0;
    forever begin
      @(posedge clk); #1;
      bus.alu_result_valid = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack             = spur_req;
        bus.alu_result_valid = 1'b1;
        bus.alu_result       = spur_data;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.alu_result_valid = 1'b1;
          bus.alu_result       = pend_res;
        end
      end
      if (bus.alu_valid) begin
        n_issue++;
        cap_a   = bus.alu_opA;
        cap_b   = bus.alu_opB;
        cap_sel = bus.alu_selector;
        sel_log = {sel_log[20:0], bus.alu_selector};
        if (alu_delay > 0) begin
          wait_cnt = alu_delay;
          pend_res = alu_model(bus.alu_opA, bus.alu_opB, bus.alu_selector);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    @(negedge clk);
    chk(tag, dbg_data, exp);
  endtask

  // Holds instr_valid until the word is accepted, then drops it at #1 after the accepting edge.
  task automatic push(input logic [15:0] w);
    int n = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    while (!bus.instr_ready) begin
      if (n >= 300) begin
        chk("push_wait", {31'd0, bus.instr_ready}, 32'd1);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    dbg_addr        = 3'd3;

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_ready",   {31'd0, bus.instr_ready}, 32'd0);
    chk("rst_valid",   {31'd0, bus.alu_valid}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_err",     {31'd0, err}, 32'd0);
    chk("rst_retired", {16'd0, retired_count}, 32'd0);
    chk("rst_dbg",     dbg_data, 32'd0);
    rst = 1'b0;
    chk("ready_at_release", {31'd0, bus.instr_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_clk", {31'd0, bus.instr_ready}, 32'd1);

    // 1: LOADI R1=5, LOADI R2=3, ADD R3=R1+R2
    alu_delay = 1;
    push(16'hE405);
    dbg_addr = 3'd1;
    @(posedge clk); #1;
    chk("ldi_edge1", dbg_data, 32'd0);
    @(posedge clk); #1;
    chk("ldi_edge2", dbg_data, 32'd5);
    push(16'hE803);
    push(16'h0CA0);
    wait_idle("t1_idle");
    chk("t1_opA", cap_a, 32'd5);
    chk("t1_opB", cap_b, 32'd3);
    chk("t1_sel", {29'd0, cap_sel}, 32'd0);
    chk("t1_issues", n_issue, 32'd1);
    chk_reg("t1_r3", 3'd3, 32'd8);
    chk("t1_retired", {16'd0, retired_count}, 32'd3);

    // 2: stalled ALU with a full FIFO. E and F depend on earlier results, so the final values check ordering.
    alu_delay = 12;
    base = n_issue;
    push(16'h10A0);   // R4 = R1 + R2 = 8
    push(16'h3590);   // R5 = R3 - R1 = 3
    push(16'h59C0);   // R6 = R3 & R4 = 8
    push(16'h7CA0);   // R7 = R1 | R2 = 7
    push(16'h9250);   // R4 = R4 ^ R5 = 11
    chk("t2_full_ready", {31'd0, bus.instr_ready}, 32'd0);
    push(16'h1660);   // R5 = R4 + R6 = 19, accepted only once the FIFO head pops
    chk("t2_late_accept", {16'd0, retired_count}, 32'd4);
    wait_idle("t2_idle");
    chk("t2_issues", n_issue - base, 32'd6);
    chk("t2_order", {14'd0, sel_log[17:0]}, 32'h000014E0);
    chk_reg("t2_r4", 3'd4, 32'd11);
    chk_reg("t2_r5", 3'd5, 32'd19);
    chk_reg("t2_r6", 3'd6, 32'd8);
    chk_reg("t2_r7", 3'd7, 32'd7);
    chk("t2_retired", {16'd0, retired_count}, 32'd9);

    // 3: rd = R0 is issued and retires, but the write is discarded
    alu_delay = 1;
    base = n_issue;
    push(16'hA0A0);
    wait_idle("t3_idle");
    chk("t3_issues", n_issue - base, 32'd1);
    chk("t3_sel", {29'd0, cap_sel}, 32'd5);
    chk_reg("t3_r0", 3'd0, 32'd0);
    chk("t3_retired", {16'd0, retired_count}, 32'd10);

    // 4: ALU never answers. G times out and H (LOADI R2=9) still runs.
    alu_delay = 0;
    base = n_issue;
    push(16'h1C90);   // R7 = R1 + R1, accepted at E1
    push(16'hE809);   // accepted at E2. The loop below counts edges from E2 onwards.
    n = 0;
    while (!err && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_timeout_edge", n, 32'd65);
    chk("t4_err", {31'd0, err}, 32'd1);
    wait_idle("t4_idle");
    chk("t4_issues", n_issue - base, 32'd1);
    chk_reg("t4_r7", 3'd7, 32'd7);
    chk_reg("t4_r2", 3'd2, 32'd9);
    chk("t4_retired", {16'd0, retired_count}, 32'd11);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);

    // 5: reset while in WAIT, then a late result arrives after release
    base = n_issue;
    push(16'h0520);   // R1 = R2 + R2
    repeat (5) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_ready",   {31'd0, bus.instr_ready}, 32'd0);
    chk("t5_rst_busy",    {31'd0, busy}, 32'd0);
    chk("t5_rst_valid",   {31'd0, bus.alu_valid}, 32'd0);
    chk("t5_rst_opA",     bus.alu_opA, 32'd0);
    chk("t5_rst_err",     {31'd0, err}, 32'd0);
    chk("t5_rst_retired", {16'd0, retired_count}, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    spur_data = 32'hDEADBEEF;
    spur_req++;
    repeat (4) @(posedge clk); #1;
    chk("t5_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("t5_busy",  {31'd0, busy}, 32'd0);
    chk("t5_issues", n_issue - base, 32'd1);
    chk_reg("t5_r1", 3'd1, 32'd0);
    chk_reg("t5_r2", 3'd2, 32'd0);
    chk("t5_retired", {16'd0, retired_count}, 32'd0);

    // 6: spurious result while IDLE, then LOADI with the largest immediate
    alu_delay = 1;
    push(16'hE405);
    wait_idle("t6_idle_a");
    chk("t6_retired_a", {16'd0, retired_count}, 32'd1);
    spur_data = 32'h00001234;
    spur_req++;
    repeat (4) @(posedge clk); #1;
    chk_reg("t6_r1", 3'd1, 32'd5);
    chk("t6_retired_b", {16'd0, retired_count}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    push(16'hFBFF);
    wait_idle("t6_idle_b");
    chk_reg("t6_r6_imm_max", 3'd6, 32'h000003FF);
    chk("t6_retired_c", {16'd0, retired_count}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
